pipe_stage_skid: RTL and testbench
==================================

# pipe_stage_skid

Parametrised pipeline-stage register that replaces the fixed-field ID/EX-style latches with a generic stage that carries a control word and a data word. It has valid/ready handshaking, a two-entry skid buffer, flush (bubble injection) and a stall-cycle counter. One instance sits between each pair of pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). Back-pressure from a stalled downstream stage never forces a combinational ready path upstream.

## Interface
- CTRL_W, 16: width of the control word (MemRead, MemWrite, RegWrite, ALUOp, branch flags, ...).
- DATA_W, 160: width of the data word (opcode, reg operands, imm, pc, addresses).
- CTRL_NOP, 0: control value presented whenever the output is invalid, and loaded on flush/reset.
- CNT_W, 16: width of the stall counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  discard all held entries; highest priority.
- in_valid  in  1  upstream has a stage word.
- in_ready  out  1  stage can accept; registered, equals !skid_valid.
- in_ctrl  in  CTRL_W  upstream control word.
- in_data  in  DATA_W  upstream data word.
- out_valid  out  1  main entry holds a word.
- out_ready  in  1  downstream consumes this cycle.
- out_ctrl  out  CTRL_W  main control; forced to CTRL_NOP when out_valid=0.
- out_data  out  DATA_W  main data; don't-care when invalid, zero after reset.
- occupancy  out  2  entries held (0, 1, 2).
- stall_cnt  out  CNT_W  saturating count of cycles with out_valid & !out_ready.
- stall_clr  in  1  synchronous clear of stall_cnt.

## Operation
- Storage: main entry (drives outputs) and skid entry, each with valid, ctrl and data.
- accept = in_valid & in_ready; consume = out_valid & out_ready.
- States are encoded by (main_valid, skid_valid):
  - EMPTY: accept -> ONE, main loads input.
  - ONE: accept & consume -> ONE, main loads input. accept & !consume -> FULL, skid loads input. !accept & consume -> EMPTY.
  - FULL: in_ready=0. consume -> ONE, main loads skid, skid cleared.
- flush: next state is EMPTY; both valids are cleared and both ctrl fields load CTRL_NOP. An input presented in the same cycle is dropped. Data is not cleared.
- Word order is strictly FIFO; no word is duplicated or lost except by flush.
- stall_cnt:
  - +1 each cycle with out_valid & !out_ready.
  - Saturates at 2^CNT_W-1.
  - stall_clr has priority over increment.
  - flush does not clear it.

## Timing
- Reset values: out_valid=0, in_ready=1, out_ctrl=CTRL_NOP, out_data=0, occupancy=0, stall_cnt=0. Skid entry is invalid, its ctrl is CTRL_NOP and its data is zero.
- Latency: an input accepted at edge N is visible on the outputs after edge N when the stage was EMPTY, or ONE with consume.
- Throughput: 1 word/cycle with out_ready held high.
- in_ready drops the cycle after the skid fills. It rises the cycle after a consume in FULL.
- Upstream must hold in_ctrl and in_data stable while in_valid & !in_ready. Downstream may deassert out_ready at any time.
- Simultaneous events:
  - rst overrides flush.
  - flush overrides accept and consume. A consume asserted in the flush cycle is still counted as taken by downstream.
- Reset mid-operation discards all entries on the next edge.

## Structure
- Shared package pipe_pkg holds:
  - the occupancy/state encoding (EMPTY=0, ONE=1, FULL=2);
  - the default CTRL_NOP;
  - per-stage CTRL_W/DATA_W localparams (ID_EX_CTRL_W, ID_EX_DATA_W, ...);
  - helper field-offset constants for packing ID/EX fields.
- One sub-module is natural: pipe_entry, a single valid+ctrl+data register slot with load, clear-to-NOP and reset. It is instantiated twice (main, skid).
- Control logic (accept/consume, next-state, mux main<-input/skid) lives in the top.

## Test plan
- Reset then idle:
  - Stimulus: rst=1 for 2 cycles, then release.
  - Required: out_valid=0, in_ready=1, out_ctrl=0, occupancy=0, stall_cnt=0.
- Streaming:
  - Stimulus: out_ready=1; words 0x01..0x08 sent on consecutive cycles.
  - Required: each word appears one cycle later, in order, with no bubbles; occupancy stays at 1.
- Back-pressure:
  - Stimulus: out_ready=0 while sending A=0x11, B=0x22, C=0x33.
  - Required: A is held at the output; B is held in the skid; in_ready=0 and C stays pending.
  - Then with out_ready=1: A, B and C drain in order, and stall_cnt equals the number of stalled cycles.
- Flush while FULL:
  - Stimulus: flush=1 with in_valid=1 (D=0x44).
  - Required: next cycle out_valid=0, out_ctrl=CTRL_NOP, occupancy=0, in_ready=1, and D is never output.
- Stall counter:
  - Stimulus: CNT_W=4 and 20 stalled cycles.
  - Required: stall_cnt saturates at 15. stall_clr together with a stall gives stall_cnt=0 next cycle.
- Reset mid-FULL:
  - Stimulus: rst with both entries valid.
  - Required: all outputs return to reset values in one cycle.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the generic pipeline-stage register: state encoding,
// the default NOP control word, per-stage widths and ID/EX field offsets.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  localparam int unsigned CTRL_NOP_DEFAULT = 0;

  localparam int unsigned IF_ID_CTRL_W  = 16;
  localparam int unsigned IF_ID_DATA_W  = 64;
  localparam int unsigned ID_EX_CTRL_W  = 16;
  localparam int unsigned ID_EX_DATA_W  = 160;
  localparam int unsigned EX_MEM_CTRL_W = 16;
  localparam int unsigned EX_MEM_DATA_W = 128;
  localparam int unsigned MEM_WB_CTRL_W = 16;
  localparam int unsigned MEM_WB_DATA_W = 96;

  // ID/EX data word layout, LSB first; 150 of the 160 bits are used.
  localparam int unsigned ID_EX_OPCODE_LSB  = 0;
  localparam int unsigned ID_EX_OPCODE_W    = 7;
  localparam int unsigned ID_EX_RS1_LSB     = 7;
  localparam int unsigned ID_EX_RS2_LSB     = 12;
  localparam int unsigned ID_EX_RD_LSB      = 17;
  localparam int unsigned ID_EX_REG_W       = 5;
  localparam int unsigned ID_EX_IMM_LSB     = 22;
  localparam int unsigned ID_EX_RS2_VAL_LSB = 54;
  localparam int unsigned ID_EX_RS1_VAL_LSB = 86;
  localparam int unsigned ID_EX_PC_LSB      = 118;
  localparam int unsigned ID_EX_WORD_W      = 32;

endpackage

// File: rtl/pipe_entry.sv
// Single valid+ctrl+data register slot. Reset zeroes data and loads the NOP
// control; clear drops the word (ctrl back to NOP) but leaves data untouched.
module pipe_entry
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W = 16,
  parameter int unsigned DATA_W = 160,
  parameter logic [CTRL_W-1:0] CTRL_NOP = CTRL_W'(CTRL_NOP_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load,
  input  logic [CTRL_W-1:0] load_ctrl,
  input  logic [DATA_W-1:0] load_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      ctrl  <= CTRL_NOP;
      data  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
      ctrl  <= CTRL_NOP;
    end else if (load) begin
      valid <= 1'b1;
      ctrl  <= load_ctrl;
      data  <= load_data;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Generic pipeline-stage register with a two-entry skid buffer, flush and a
// saturating stall counter; in_ready is a flop output, so no comb ready path.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W = ID_EX_CTRL_W,
  parameter int unsigned DATA_W = ID_EX_DATA_W,
  parameter logic [CTRL_W-1:0] CTRL_NOP = CTRL_W'(CTRL_NOP_DEFAULT),
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  input  logic              stall_clr
);

  logic              main_valid, skid_valid;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic [DATA_W-1:0] main_data, skid_data;

  logic              main_load, main_clr, main_from_skid;
  logic              skid_load, skid_clr;
  logic [CTRL_W-1:0] main_load_ctrl;
  logic [DATA_W-1:0] main_load_data;
  logic              accept, consume;
  state_e            state;

  // The two valid bits are the state register.
  always_comb begin
    if (skid_valid)      state = ST_FULL;
    else if (main_valid) state = ST_ONE;
    else                 state = ST_EMPTY;
  end

  assign in_ready = !skid_valid;
  assign accept   = in_valid & in_ready;
  assign consume  = main_valid & out_ready;

  always_comb begin
    main_load      = 1'b0;
    main_clr       = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clr       = 1'b0;
    if (flush) begin
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      unique case (state)
        ST_EMPTY: main_load = accept;
        ST_ONE: begin
          if (accept) begin
            main_load = consume;
            skid_load = !consume;
          end else begin
            main_clr = consume;
          end
        end
        ST_FULL: begin
          main_load      = consume;
          main_from_skid = consume;
          skid_clr       = consume;
        end
        default: begin
          main_clr = 1'b1;
          skid_clr = 1'b1;
        end
      endcase
    end
  end

  assign main_load_ctrl = main_from_skid ? skid_ctrl : in_ctrl;
  assign main_load_data = main_from_skid ? skid_data : in_data;

  pipe_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CTRL_NOP(CTRL_NOP)) u_main (
    .clk       (clk),
    .rst       (rst),
    .clear     (main_clr),
    .load      (main_load),
    .load_ctrl (main_load_ctrl),
    .load_data (main_load_data),
    .valid     (main_valid),
    .ctrl      (main_ctrl),
    .data      (main_data)
  );

  pipe_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CTRL_NOP(CTRL_NOP)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .clear     (skid_clr),
    .load      (skid_load),
    .load_ctrl (in_ctrl),
    .load_data (in_data),
    .valid     (skid_valid),
    .ctrl      (skid_ctrl),
    .data      (skid_data)
  );

  assign out_valid = main_valid;
  assign out_ctrl  = main_valid ? main_ctrl : CTRL_NOP;
  assign out_data  = main_data;
  assign occupancy = state;

  always_ff @(posedge clk) begin
    if (rst || stall_clr) begin
      stall_cnt <= '0;
    end else if (main_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed-vector bench for pipe_stage_skid with hand-computed expectations.
module tb_pipe_stage_skid;

  localparam int CTRL_W = 16;
  localparam int DATA_W = 160;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst, flush, in_valid, in_ready, out_valid, out_ready, stall_clr;
  logic [CTRL_W-1:0] in_ctrl, out_ctrl;
  logic [DATA_W-1:0] in_data, out_data;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_stage_skid #(
    .CTRL_W   (CTRL_W),
    .DATA_W   (DATA_W),
    .CTRL_NOP ('0),
    .CNT_W    (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
    .occupancy (occupancy),
    .stall_cnt (stall_cnt),
    .stall_clr (stall_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [159:0] mk(input logic [7:0] w);
    return {w, 144'h0, w};
  endfunction

  // Advance one edge; outputs are then sampled 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] w);
    in_valid = 1'b1;
    in_ctrl  = {8'h00, w};
    in_data  = mk(w);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".out_valid"}, out_valid, 1'b0);
    check({tag, ".in_ready"},  in_ready,  1'b1);
    check({tag, ".out_ctrl"},  out_ctrl,  16'h0);
    check({tag, ".out_data"},  out_data,  160'h0);
    check({tag, ".occupancy"}, occupancy, 2'd0);
    check({tag, ".stall_cnt"}, stall_cnt, 4'd0);
  endtask

  task automatic check_head(input string tag, input logic [7:0] w, input logic [1:0] occ);
    check({tag, ".out_valid"}, out_valid, 1'b1);
    check({tag, ".out_ctrl"},  out_ctrl,  {8'h00, w});
    check({tag, ".out_data"},  out_data,  mk(w));
    check({tag, ".occupancy"}, occupancy, occ);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; stall_clr = 1'b0;
    in_ctrl = '0; in_data = '0;
    step();
    step();
    rst = 1'b0;
    check_reset_state("reset");
    step();
    check_reset_state("idle");

    // Streaming: each word visible right after its accepting edge.
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      send(8'(i));
      step();
      check_head($sformatf("stream%0d", i), 8'(i), 2'd1);
      check($sformatf("stream%0d.in_ready", i), in_ready, 1'b1);
    end
    in_valid = 1'b0;
    step();
    check("stream_end.out_valid", out_valid, 1'b0);
    check("stream_end.occupancy", occupancy, 2'd0);
    check("stream_end.stall_cnt", stall_cnt, 4'd0);

    // Back-pressure: A held, B in skid, C pending.
    out_ready = 1'b0;
    send(8'h11);
    step();
    check_head("bp_a", 8'h11, 2'd1);
    check("bp_a.stall_cnt", stall_cnt, 4'd0);
    send(8'h22);
    step();
    check_head("bp_b", 8'h11, 2'd2);
    check("bp_b.in_ready", in_ready, 1'b0);
    check("bp_b.stall_cnt", stall_cnt, 4'd1);
    send(8'h33);
    step();
    check_head("bp_c1", 8'h11, 2'd2);
    check("bp_c1.in_ready", in_ready, 1'b0);
    step();
    check_head("bp_c2", 8'h11, 2'd2);
    check("bp_c2.stall_cnt", stall_cnt, 4'd3);
    out_ready = 1'b1;
    step();
    check_head("drain_b", 8'h22, 2'd1);
    check("drain_b.in_ready", in_ready, 1'b1);
    step();
    check_head("drain_c", 8'h33, 2'd1);
    in_valid = 1'b0;
    step();
    check("drain_end.out_valid", out_valid, 1'b0);
    check("drain_end.stall_cnt", stall_cnt, 4'd3);

    // Flush while FULL, with D presented in the flush cycle.
    out_ready = 1'b0;
    send(8'h55);
    step();
    send(8'h66);
    step();
    check_head("pre_flush", 8'h55, 2'd2);
    check("pre_flush.stall_cnt", stall_cnt, 4'd4);
    flush = 1'b1;
    send(8'h44);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    check("flush.out_valid", out_valid, 1'b0);
    check("flush.out_ctrl",  out_ctrl,  16'h0);
    check("flush.occupancy", occupancy, 2'd0);
    check("flush.in_ready",  in_ready,  1'b1);
    check("flush.stall_cnt", stall_cnt, 4'd5);
    out_ready = 1'b1;
    step();
    check("post_flush.out_valid", out_valid, 1'b0);

    // Stall counter saturation and clear priority.
    stall_clr = 1'b1;
    step();
    stall_clr = 1'b0;
    check("clr.stall_cnt", stall_cnt, 4'd0);
    out_ready = 1'b0;
    send(8'h77);
    step();
    in_valid = 1'b0;
    check("sat0.stall_cnt", stall_cnt, 4'd0);
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 14 || i == 15 || i == 20)
        check($sformatf("sat%0d.stall_cnt", i), stall_cnt, (i < 15) ? 4'(i) : 4'd15);
    end
    check_head("sat_hold", 8'h77, 2'd1);
    stall_clr = 1'b1;
    step();
    stall_clr = 1'b0;
    check("clr_with_stall.stall_cnt", stall_cnt, 4'd0);
    step();
    check("after_clr.stall_cnt", stall_cnt, 4'd1);

    // Reset while FULL.
    send(8'h88);
    step();
    in_valid = 1'b0;
    check_head("pre_rst", 8'h77, 2'd2);
    rst = 1'b1;
    flush = 1'b1;
    step();
    rst = 1'b0;
    flush = 1'b0;
    check_reset_state("mid_rst");
    out_ready = 1'b1;
    send(8'h99);
    step();
    in_valid = 1'b0;
    check_head("post_rst", 8'h99, 2'd1);
    step();
    check("post_rst_end.out_valid", out_valid, 1'b0);
    check("post_rst_end.occupancy", occupancy, 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
